// File: rtl/rv_multicycle_datapath.sv
// ----------------------------------------------------------------------------
// rv_multicycle_datapath
//
// Multi-cycle RV32I datapath with its own phase sequencer
// (FETCH -> EXEC -> [MEM] -> WB). Decode control comes from an external
// controller that looks at Instr. Branch/jump resolution is done here.
//
// Ports:
//   clk, rst_n        rising-edge clock; rst_n is a synchronous, ACTIVE-HIGH
//                     reset (1 = reset) despite its legacy name
//   PC                current instruction address
//   imem_req/ready/rdata   valid/ready instruction fetch port
//   Instr             instruction register contents (to the controller)
//   RegWrite, ImmSrc, ALUSrc, ALUControl, ResultSrc, Branch, Jump,
//   MemRead, MemWrite control inputs, held stable from EXEC through WB
//   dmem_req/we/addr/wdata/ready/rdata   valid/ready data port
//   ALUResult, Zero   registered ALU result and zero flag
//   instr_done        one-cycle pulse in the write-back phase
// ----------------------------------------------------------------------------
module rv_multicycle_datapath #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] PC,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     Instr,
    input  logic            RegWrite,
    input  logic [2:0]      ImmSrc,
    input  logic            ALUSrc,
    input  logic [2:0]      ALUControl,
    input  logic [1:0]      ResultSrc,
    input  logic            Branch,
    input  logic            Jump,
    input  logic            MemRead,
    input  logic            MemWrite,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            instr_done
);

    localparam int              RIW       = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0
    localparam logic [XLEN-1:0] ZERO_X    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] FOUR_X    = {{(XLEN-3){1'b0}}, 3'b100};

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t          state_r;
    logic [XLEN-1:0] pc_r;
    logic [31:0]     ir_r;
    logic [XLEN-1:0] alu_out_r;
    logic            zero_r;
    logic [XLEN-1:0] rd2_r;
    logic [XLEN-1:0] imm_r;
    logic [XLEN-1:0] pc4_r;
    logic [XLEN-1:0] target_r;
    logic [XLEN-1:0] load_r;
    logic            store_r;
    logic [XLEN-1:0] rf_r [NREGS];

    logic [4:0]      rs1_idx_s;
    logic [4:0]      rs2_idx_s;
    logic [4:0]      rd_idx_s;
    logic [XLEN-1:0] rs1_s;
    logic [XLEN-1:0] rs2_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] imm_ext_s;
    logic [XLEN-1:0] src_b_s;
    logic            lt_s;
    logic [XLEN-1:0] alu_s;
    logic [XLEN-1:0] result_s;
    logic            rd_write_s;
    logic            take_target_s;

    // Indices at or above NREGS do not exist (RV32E case): read 0, drop writes.
    function automatic logic reg_exists(input logic [4:0] idx);
        return (32'(idx) < NREGS);
    endfunction

    assign rs1_idx_s = ir_r[19:15];
    assign rs2_idx_s = ir_r[24:20];
    assign rd_idx_s  = ir_r[11:7];

    // Combinational register file read ports; x0 and missing registers read 0.
    always_comb begin
        if ((rs1_idx_s != 5'd0) && reg_exists(rs1_idx_s)) begin
            rs1_s = rf_r[rs1_idx_s[RIW-1:0]];
        end else begin
            rs1_s = ZERO_X;
        end
        if ((rs2_idx_s != 5'd0) && reg_exists(rs2_idx_s)) begin
            rs2_s = rf_r[rs2_idx_s[RIW-1:0]];
        end else begin
            rs2_s = ZERO_X;
        end
    end

    // Immediate generator; every format is sign-extended from bit 31.
    always_comb begin
        case (ImmSrc)
            3'b000:  imm32_s = {{20{ir_r[31]}}, ir_r[31:20]};
            3'b001:  imm32_s = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
            3'b010:  imm32_s = {{20{ir_r[31]}}, ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
            3'b011:  imm32_s = {{12{ir_r[31]}}, ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
            3'b100:  imm32_s = {ir_r[31:12], 12'h000};
            default: imm32_s = 32'h0000_0000;
        endcase
        imm_ext_s = XLEN'($signed(imm32_s));
    end

    // ALU: add/sub wrap, slt is signed, unknown encodings give 0.
    always_comb begin
        if (ALUSrc) begin
            src_b_s = imm_ext_s;
        end else begin
            src_b_s = rs2_s;
        end
        lt_s = ($signed(rs1_s) < $signed(src_b_s));
        case (ALUControl)
            3'b000:  alu_s = rs1_s + src_b_s;
            3'b001:  alu_s = rs1_s - src_b_s;
            3'b010:  alu_s = rs1_s & src_b_s;
            3'b011:  alu_s = rs1_s | src_b_s;
            3'b101:  alu_s = {{(XLEN-1){1'b0}}, lt_s};
            default: alu_s = ZERO_X;
        endcase
    end

    // Write-back value select and next-PC decision, both from latched EXEC data.
    always_comb begin
        case (ResultSrc)
            2'b00:   result_s = alu_out_r;
            2'b01:   result_s = load_r;
            2'b10:   result_s = pc4_r;
            2'b11:   result_s = imm_r;
            default: result_s = alu_out_r;
        endcase
        take_target_s = (Branch & zero_r) | Jump;
        rd_write_s    = RegWrite && (rd_idx_s != 5'd0) && reg_exists(rd_idx_s);
    end

    // Handshake outputs decode the state register and are gated off in reset.
    assign imem_req   = !rst_n && (state_r == S_FETCH);
    assign dmem_req   = !rst_n && (state_r == S_MEM);
    assign dmem_we    = !rst_n && (state_r == S_MEM) && store_r;
    assign instr_done = !rst_n && (state_r == S_WB);

    assign PC         = pc_r;
    assign Instr      = ir_r;
    assign ALUResult  = alu_out_r;
    assign Zero       = zero_r;
    assign dmem_addr  = alu_out_r;
    assign dmem_wdata = rd2_r;

    // Phase sequencer with all architectural and pipeline-latch state.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r   <= S_FETCH;
            pc_r      <= RESET_PC;
            ir_r      <= NOP_INSTR;
            alu_out_r <= ZERO_X;
            zero_r    <= 1'b0;
            rd2_r     <= ZERO_X;
            imm_r     <= ZERO_X;
            pc4_r     <= ZERO_X;
            target_r  <= ZERO_X;
            load_r    <= ZERO_X;
            store_r   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= ZERO_X;
            end
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_r    <= imem_rdata;
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_out_r <= alu_s;
                    zero_r    <= (alu_s == ZERO_X);
                    rd2_r     <= rs2_s;
                    imm_r     <= imm_ext_s;
                    pc4_r     <= pc_r + FOUR_X;
                    target_r  <= pc_r + imm_ext_s;
                    store_r   <= MemWrite;
                    if (MemRead || MemWrite) begin
                        state_r <= S_MEM;
                    end else begin
                        state_r <= S_WB;
                    end
                end
                S_MEM: begin
                    // Address and write data stay on the latched values until ready.
                    if (dmem_ready) begin
                        if (MemRead) begin
                            load_r <= dmem_rdata;
                        end
                        state_r <= S_WB;
                    end
                end
                S_WB: begin
                    if (rd_write_s) begin
                        rf_r[rd_idx_s[RIW-1:0]] <= result_s;
                    end
                    if (take_target_s) begin
                        pc_r <= target_r;
                    end else begin
                        pc_r <= pc4_r;
                    end
                    state_r <= S_FETCH;
                end
                default: begin
                    state_r <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_multicycle_datapath.sv
// ----------------------------------------------------------------------------
// Testbench for rv_multicycle_datapath. The bench plays the external
// controller, the instruction memory and the data memory, and keeps an
// instruction-level RV32I reference model to predict PC, ALU results,
// store traffic and latencies.
// ----------------------------------------------------------------------------
module tb_rv_multicycle_datapath;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic [31:0] PC;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        RegWrite;
    logic [2:0]  ImmSrc;
    logic        ALUSrc;
    logic [2:0]  ALUControl;
    logic [1:0]  ResultSrc;
    logic        Branch;
    logic        Jump;
    logic        MemRead;
    logic        MemWrite;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        instr_done;

    rv_multicycle_datapath #(
        .XLEN(32), .NREGS(32), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .PC(PC),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .Instr(Instr), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
        .ALUControl(ALUControl), .ResultSrc(ResultSrc), .Branch(Branch),
        .Jump(Jump), .MemRead(MemRead), .MemWrite(MemWrite),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .ALUResult(ALUResult), .Zero(Zero), .instr_done(instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- external controller (decodes Instr) ----------------
    function automatic logic [2:0] alu_sel(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    always_comb begin
        RegWrite = 1'b0; ImmSrc = 3'b000; ALUSrc = 1'b0; ALUControl = 3'b000;
        ResultSrc = 2'b00; Branch = 1'b0; Jump = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        case (Instr[6:0])
            7'h13: begin RegWrite = 1'b1; ALUSrc = 1'b1; ALUControl = alu_sel(Instr[14:12], 1'b0); end
            7'h33: begin RegWrite = 1'b1; ALUControl = alu_sel(Instr[14:12], Instr[30]); end
            7'h03: begin RegWrite = 1'b1; ALUSrc = 1'b1; ResultSrc = 2'b01; MemRead = 1'b1; end
            7'h23: begin ImmSrc = 3'b001; ALUSrc = 1'b1; MemWrite = 1'b1; end
            7'h63: begin ImmSrc = 3'b010; Branch = 1'b1; ALUControl = 3'b001; end
            7'h6F: begin ImmSrc = 3'b011; Jump = 1'b1; RegWrite = 1'b1; ResultSrc = 2'b10; end
            7'h37: begin ImmSrc = 3'b100; RegWrite = 1'b1; ResultSrc = 2'b11; end
            default: begin RegWrite = 1'b0; end
        endcase
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] f_addi(input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'h13};
    endfunction
    function automatic logic [31:0] f_iop(input int f3, input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'h13};
    endfunction
    function automatic logic [31:0] f_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] f_lw(input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'h03};
    endfunction
    function automatic logic [31:0] f_sw(input int rs2, input int rs1, input int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] f_beq(input int rs1, input int rs2, input int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] f_jal(input int rd, input int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] f_lui(input int rd, input int imm);
        return {imm[19:0], rd[4:0], 7'h37};
    endfunction

    // ---------------- memories and reference model ----------------
    logic [31:0] env_mem [logic [31:0]];   // memory the DUT talks to
    logic [31:0] m_mem   [logic [31:0]];   // model's own view of memory
    logic [31:0] m_x     [32];
    logic [31:0] m_pc;

    logic [31:0] exp_alu, exp_st_addr, exp_st_data;
    logic        exp_alu_v, exp_zero, exp_zero_v, exp_mem, exp_store;

    function automatic logic [31:0] env_read(input logic [31:0] a);
        if (env_mem.exists(a)) return env_mem[a];
        return 32'h0000_0000;
    endfunction
    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (m_mem.exists(a)) return m_mem[a];
        return 32'h0000_0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_x[i] = 32'h0000_0000;
        m_pc = RST_PC;
    endtask

    // Executes one instruction at ISA level and records what should be observed.
    task automatic model_step(input logic [31:0] ins);
        logic [31:0] a, b, v, nxt, imm_i, imm_s, imm_b, imm_j;
        logic [4:0]  rd;
        a     = m_x[ins[19:15]];
        b     = m_x[ins[24:20]];
        rd    = ins[11:7];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        nxt = m_pc + 32'd4;
        exp_alu_v = 1'b0; exp_zero_v = 1'b0; exp_mem = 1'b0; exp_store = 1'b0;
        exp_alu = 32'h0; exp_zero = 1'b0; exp_st_addr = 32'h0; exp_st_data = 32'h0;
        v = 32'h0;
        case (ins[6:0])
            7'h13, 7'h33: begin
                if (ins[6:0] == 7'h33) imm_i = b;
                case (ins[14:12])
                    3'b010:  v = ($signed(a) < $signed(imm_i)) ? 32'd1 : 32'd0;
                    3'b110:  v = a | imm_i;
                    3'b111:  v = a & imm_i;
                    default: v = (ins[6:0] == 7'h33 && ins[30]) ? a - imm_i : a + imm_i;
                endcase
                exp_alu = v; exp_alu_v = 1'b1;
                if (rd != 5'd0) m_x[rd] = v;
            end
            7'h03: begin
                exp_alu = a + imm_i; exp_alu_v = 1'b1; exp_mem = 1'b1;
                if (rd != 5'd0) m_x[rd] = m_read(a + imm_i);
            end
            7'h23: begin
                exp_alu = a + imm_s; exp_alu_v = 1'b1; exp_mem = 1'b1; exp_store = 1'b1;
                exp_st_addr = a + imm_s; exp_st_data = b;
                m_mem[a + imm_s] = b;
            end
            7'h63: begin
                exp_alu = a - b; exp_alu_v = 1'b1; exp_zero = (a == b); exp_zero_v = 1'b1;
                if (a == b) nxt = m_pc + imm_b;
            end
            7'h6F: begin
                if (rd != 5'd0) m_x[rd] = m_pc + 32'd4;
                nxt = m_pc + imm_j;
            end
            7'h37: begin
                if (rd != 5'd0) m_x[rd] = {ins[31:12], 12'h000};
            end
            default: begin
                nxt = m_pc + 32'd4;
            end
        endcase
        m_pc = nxt;
    endtask

    // ---------------- bus driver (collects observations only) ----------------
    int          obs_cycles, obs_req_cycles;
    logic        obs_done, obs_st, obs_we, obs_unstable, obs_zero;
    logic [31:0] obs_pc, obs_alu, obs_addr, obs_wdata;

    task automatic run_instr(input logic [31:0] ins, input int iwait, input int dwait);
        int icnt, dcnt;
        icnt = 0; dcnt = 0;
        obs_cycles = 0; obs_req_cycles = 0; obs_done = 1'b0; obs_st = 1'b0; obs_we = 1'b0;
        obs_unstable = 1'b0; obs_zero = 1'b0; obs_pc = 32'hx; obs_alu = 32'h0;
        obs_addr = 32'h0; obs_wdata = 32'h0;
        for (int c = 0; c < 64 && !obs_done; c++) begin
            @(negedge clk);
            obs_cycles++;
            imem_ready = 1'b0; imem_rdata = $urandom;
            dmem_ready = 1'b0; dmem_rdata = $urandom;
            if (imem_req) begin
                if (icnt >= iwait) begin imem_ready = 1'b1; imem_rdata = ins; end
                icnt++;
            end else if ($urandom_range(0, 3) == 0) begin
                imem_ready = 1'b1;   // stray ready with garbage, must be ignored
            end
            if (dmem_req) begin
                if (obs_req_cycles > 0 &&
                    (dmem_addr !== obs_addr || dmem_wdata !== obs_wdata || dmem_we !== obs_we))
                    obs_unstable = 1'b1;
                obs_req_cycles++;
                obs_addr = dmem_addr; obs_wdata = dmem_wdata; obs_we = dmem_we;
                if (dcnt >= dwait) begin
                    dmem_ready = 1'b1;
                    if (dmem_we) begin env_mem[dmem_addr] = dmem_wdata; obs_st = 1'b1; end
                    else dmem_rdata = env_read(dmem_addr);
                end
                dcnt++;
            end else if ($urandom_range(0, 3) == 0) begin
                dmem_ready = 1'b1;
            end
            if (instr_done) begin obs_done = 1'b1; obs_alu = ALUResult; obs_zero = Zero; end
        end
        if (obs_done) begin
            @(posedge clk); #1;
            obs_pc = PC;
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF; dmem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_imem_req: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) $display("FAIL rst_dmem: got req=%b we=%b want 0", dmem_req, dmem_we); else n_pass++;
        n_checks++; if (instr_done !== 1'b0) $display("FAIL rst_done: got %b want 0", instr_done); else n_pass++;
        n_checks++; if (PC !== RST_PC) $display("FAIL rst_pc: got %h want %h", PC, RST_PC); else n_pass++;
        n_checks++; if (Instr !== 32'h0000_0013) $display("FAIL rst_ir: got %h want 00000013", Instr); else n_pass++;
        n_checks++; if (ALUResult !== 32'h0 || Zero !== 1'b0) $display("FAIL rst_alu: got %h/%b want 0/0", ALUResult, Zero); else n_pass++;
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL rel_imem_req: got %b want 1", imem_req); else n_pass++;
        n_checks++; if (PC !== RST_PC) $display("FAIL rel_pc: got %h want %h", PC, RST_PC); else n_pass++;
        model_reset();
    endtask

    task automatic test_alu_seq();
        logic [31:0] ins;
        ins = f_addi(1, 0, 5); model_step(ins); run_instr(ins, 0, 0);
        n_checks++; if (obs_done !== 1'b1 || obs_cycles != 3) $display("FAIL addi_latency: got done=%b cycles=%0d want 1/3", obs_done, obs_cycles); else n_pass++;
        n_checks++; if (obs_alu !== 32'd5) $display("FAIL addi_alu: got %h want 5", obs_alu); else n_pass++;
        n_checks++; if (obs_pc !== 32'h104) $display("FAIL addi_pc: got %h want 104", obs_pc); else n_pass++;
        ins = f_r(0, 1, 1, 0, 2); model_step(ins); run_instr(ins, 0, 0);
        n_checks++; if (obs_cycles != 3) $display("FAIL add_latency: got %0d want 3", obs_cycles); else n_pass++;
        n_checks++; if (obs_alu !== 32'd10) $display("FAIL add_alu: got %h want a", obs_alu); else n_pass++;
        n_checks++; if (obs_pc !== 32'h108) $display("FAIL add_pc: got %h want 108", obs_pc); else n_pass++;
    endtask

    task automatic test_store_wait();
        logic [31:0] ins;
        ins = f_sw(2, 0, 8); model_step(ins); run_instr(ins, 0, 2);
        n_checks++; if (obs_cycles != 6) $display("FAIL sw_latency: got %0d want 6", obs_cycles); else n_pass++;
        n_checks++; if (obs_req_cycles != 3) $display("FAIL sw_req_cycles: got %0d want 3", obs_req_cycles); else n_pass++;
        n_checks++; if (obs_addr !== 32'd8 || obs_wdata !== 32'd10 || obs_we !== 1'b1) $display("FAIL sw_bus: got a=%h d=%h we=%b want 8/a/1", obs_addr, obs_wdata, obs_we); else n_pass++;
        n_checks++; if (obs_unstable !== 1'b0) $display("FAIL sw_stable: got unstable=%b want 0", obs_unstable); else n_pass++;
        n_checks++; if (obs_pc !== 32'h10C) $display("FAIL sw_pc: got %h want 10c", obs_pc); else n_pass++;
    endtask

    task automatic test_branch();
        logic [31:0] ins;
        ins = f_jal(0, -236); model_step(ins); run_instr(ins, 1, 0);
        n_checks++; if (obs_pc !== 32'h20 || obs_cycles != 4) $display("FAIL jal_to_20: got pc=%h cyc=%0d want 20/4", obs_pc, obs_cycles); else n_pass++;
        ins = f_beq(1, 1, -8); model_step(ins); run_instr(ins, 0, 0);
        n_checks++; if (obs_pc !== 32'h18 || obs_zero !== 1'b1) $display("FAIL beq_taken: got pc=%h z=%b want 18/1", obs_pc, obs_zero); else n_pass++;
        ins = f_jal(0, 8); model_step(ins); run_instr(ins, 0, 0);
        ins = f_beq(1, 2, 64); model_step(ins); run_instr(ins, 0, 0);
        n_checks++; if (obs_pc !== 32'h24 || obs_zero !== 1'b0) $display("FAIL beq_not_taken: got pc=%h z=%b want 24/0", obs_pc, obs_zero); else n_pass++;
    endtask

    task automatic test_jump_load();
        logic [31:0] ins;
        ins = f_jal(0, 28); model_step(ins); run_instr(ins, 0, 0);
        ins = f_jal(1, 16); model_step(ins); run_instr(ins, 0, 0);
        n_checks++; if (obs_pc !== 32'h50) $display("FAIL jal_link_pc: got %h want 50", obs_pc); else n_pass++;
        ins = f_sw(1, 0, 0); model_step(ins); run_instr(ins, 0, 0);
        n_checks++; if (obs_wdata !== 32'h44) $display("FAIL jal_link_x1: got %h want 44", obs_wdata); else n_pass++;
        ins = f_lw(0, 0, 8); model_step(ins); run_instr(ins, 0, 0);
        n_checks++; if (obs_cycles != 4 || obs_we !== 1'b0) $display("FAIL lw_x0_latency: got %0d we=%b want 4/0", obs_cycles, obs_we); else n_pass++;
        ins = f_sw(0, 0, 4); model_step(ins); run_instr(ins, 0, 0);
        n_checks++; if (obs_wdata !== 32'h0) $display("FAIL x0_stays_zero: got %h want 0", obs_wdata); else n_pass++;
        ins = f_lw(4, 0, 8); model_step(ins); run_instr(ins, 0, 1);
        n_checks++; if (obs_cycles != 5) $display("FAIL lw_wait_latency: got %0d want 5", obs_cycles); else n_pass++;
        ins = f_sw(4, 0, 12); model_step(ins); run_instr(ins, 0, 0);
        n_checks++; if (obs_wdata !== 32'd10) $display("FAIL lw_data: got %h want a", obs_wdata); else n_pass++;
    endtask

    task automatic test_reset_mid_mem();
        logic [31:0] ins;
        ins = f_lw(3, 0, 8);
        @(negedge clk); imem_ready = 1'b1; imem_rdata = ins;
        @(negedge clk); imem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (dmem_req !== 1'b1) $display("FAIL midmem_in_mem: got req=%b want 1", dmem_req); else n_pass++;
        dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF; imem_ready = 1'b1; rst_n = 1'b1;
        #1;
        n_checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b0 || instr_done !== 1'b0) $display("FAIL midmem_forced: got d=%b i=%b done=%b want 0", dmem_req, imem_req, instr_done); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (PC !== RST_PC || Instr !== 32'h0000_0013) $display("FAIL midmem_reset: got pc=%h ir=%h want %h/00000013", PC, Instr, RST_PC); else n_pass++;
        rst_n = 1'b0; dmem_ready = 1'b0; imem_ready = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || dmem_req !== 1'b0) $display("FAIL midmem_fetch: got i=%b d=%b want 1/0", imem_req, dmem_req); else n_pass++;
        model_reset();
        ins = f_sw(3, 0, 16); model_step(ins); run_instr(ins, 0, 0);
        n_checks++; if (obs_wdata !== 32'h0 || obs_pc !== 32'h104) $display("FAIL midmem_no_write: got x3=%h pc=%h want 0/104", obs_wdata, obs_pc); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] ins;
        int kind, iw, dw, lat;
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 10);
            case (kind)
                0, 1, 2: ins = f_addi($urandom_range(0, 7), $urandom_range(0, 7), $urandom);
                3: begin
                    case ($urandom_range(0, 2))
                        0:       ins = f_iop(2, $urandom_range(1, 7), $urandom_range(0, 7), $urandom);
                        1:       ins = f_iop(6, $urandom_range(1, 7), $urandom_range(0, 7), $urandom);
                        default: ins = f_iop(7, $urandom_range(1, 7), $urandom_range(0, 7), $urandom);
                    endcase
                end
                4, 5: begin
                    case ($urandom_range(0, 4))
                        0:       ins = f_r(0,  $urandom_range(0, 7), $urandom_range(0, 7), 0, $urandom_range(0, 7));
                        1:       ins = f_r(32, $urandom_range(0, 7), $urandom_range(0, 7), 0, $urandom_range(0, 7));
                        2:       ins = f_r(0,  $urandom_range(0, 7), $urandom_range(0, 7), 7, $urandom_range(0, 7));
                        3:       ins = f_r(0,  $urandom_range(0, 7), $urandom_range(0, 7), 6, $urandom_range(0, 7));
                        default: ins = f_r(0,  $urandom_range(0, 7), $urandom_range(0, 7), 2, $urandom_range(0, 7));
                    endcase
                end
                6: ins = f_lw($urandom_range(0, 7), 0, 4 * $urandom_range(0, 63));
                7: ins = f_sw($urandom_range(0, 7), 0, 4 * $urandom_range(0, 63));
                8: ins = f_beq($urandom_range(0, 3), $urandom_range(0, 3), 4 * (int'($urandom_range(0, 127)) - 64));
                9: ins = f_jal($urandom_range(0, 7), 4 * (int'($urandom_range(0, 511)) - 256));
                default: ins = f_lui($urandom_range(0, 7), $urandom);
            endcase
            iw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            model_step(ins);
            run_instr(ins, iw, dw);
            lat = 3 + iw + (exp_mem ? 1 + dw : 0);
            n_checks++; if (obs_done !== 1'b1 || obs_cycles != lat) $display("FAIL rnd_latency[%0d] %h: got done=%b cyc=%0d want 1/%0d", n, ins, obs_done, obs_cycles, lat); else n_pass++;
            n_checks++; if (obs_pc !== m_pc) $display("FAIL rnd_pc[%0d] %h: got %h want %h", n, ins, obs_pc, m_pc); else n_pass++;
            if (exp_alu_v) begin
                n_checks++; if (obs_alu !== exp_alu) $display("FAIL rnd_alu[%0d] %h: got %h want %h", n, ins, obs_alu, exp_alu); else n_pass++;
            end
            if (exp_zero_v) begin
                n_checks++; if (obs_zero !== exp_zero) $display("FAIL rnd_zero[%0d] %h: got %b want %b", n, ins, obs_zero, exp_zero); else n_pass++;
            end
            if (exp_store) begin
                n_checks++; if (obs_st !== 1'b1 || obs_addr !== exp_st_addr || obs_wdata !== exp_st_data || obs_unstable !== 1'b0)
                    $display("FAIL rnd_store[%0d] %h: got st=%b a=%h d=%h uns=%b want 1/%h/%h/0", n, ins, obs_st, obs_addr, obs_wdata, obs_unstable, exp_st_addr, exp_st_data);
                else n_pass++;
            end else if (exp_mem) begin
                n_checks++; if (obs_we !== 1'b0 || obs_req_cycles != 1 + dw) $display("FAIL rnd_load_bus[%0d] %h: got we=%b req=%0d want 0/%0d", n, ins, obs_we, obs_req_cycles, 1 + dw); else n_pass++;
            end
        end
    endtask

    task automatic test_reg_dump();
        logic [31:0] ins;
        for (int i = 0; i < 8; i++) begin
            ins = f_sw(i, 0, 256 + 4 * i); model_step(ins); run_instr(ins, 0, $urandom_range(0, 1));
            n_checks++; if (obs_wdata !== exp_st_data || obs_addr !== exp_st_addr) $display("FAIL dump_x%0d: got a=%h d=%h want %h/%h", i, obs_addr, obs_wdata, exp_st_addr, exp_st_data); else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            logic [31:0] v;
            v = $urandom;
            env_mem[32'(4 * i)] = v;
            m_mem[32'(4 * i)]   = v;
        end
        test_reset();
        test_alu_seq();
        test_store_wait();
        test_branch();
        test_jump_load();
        test_reset_mid_mem();
        test_random();
        test_reg_dump();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_datapath.md
Name: rv_multicycle_datapath

Overview:
Parametrised multi-cycle RV32I datapath with an internal phase sequencer. It fetches through a valid/ready instruction port, holds the instruction in an internal IR, and executes with registered ALU results. Loads and stores go through a valid/ready data port, and registers are written back in a final phase. Decode control still comes from the external controller. Branch/jump resolution (PCSrc) is computed inside the block.

Parameters:
XLEN, 32, datapath/register width; immediates sign-extended to XLEN.
NREGS, 32, architectural registers (32 = RV32I, 16 = RV32E); index width log2(NREGS).
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset; synchronous, active-high (1 = reset) despite the legacy name.
PC  out  XLEN  current instruction address.
imem_req  out  1  fetch request.
imem_ready  in  1  fetch data valid this cycle.
imem_rdata  in  32  fetched instruction.
Instr  out  32  IR contents, fed to the external controller.
RegWrite  in  1  write rd in WB.
ImmSrc  in  3  000 I, 001 S, 010 B, 011 J, 100 U.
ALUSrc  in  1  0 = RD2, 1 = ImmExt.
ALUControl  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt, others → 0.
ResultSrc  in  2  00 ALUOut, 01 load data, 10 PC+4, 11 ImmExt (lui).
Branch  in  1  conditional branch (beq).
Jump  in  1  jal.
MemRead  in  1  instruction is a load.
MemWrite  in  1  instruction is a store.
dmem_req  out  1  data access request.
dmem_we  out  1  1 = store.
dmem_addr  out  XLEN  ALUOut.
dmem_wdata  out  XLEN  rs2 value latched in EXEC.
dmem_ready  in  1  access complete; load data valid.
dmem_rdata  in  XLEN  load data.
ALUResult  out  XLEN  registered ALUOut.
Zero  out  1  registered ALU zero flag.
instr_done  out  1  one-cycle pulse on WB.

Behaviour:
- State machine: FETCH → EXEC → (MEM if MemRead|MemWrite) → WB → FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ready: IR ← imem_rdata, go to EXEC.
  - Otherwise stay in FETCH with req held high.
- EXEC (1 cycle):
  - Read rs1/rs2 from IR[19:15]/IR[24:20].
  - Compute ALU.
  - Latch ALUOut, Zero, RD2, ImmExt, PC+4, PC+ImmExt.
- MEM:
  - dmem_req=1, dmem_we=MemWrite; address/data stable until dmem_ready.
  - On dmem_ready with a load: latch dmem_rdata. Then go to WB.
- WB:
  - If RegWrite and rd≠0: rf[rd] ← Result.
  - PC ← PCTarget if (Branch&Zero)|Jump, else PC+4.
  - instr_done=1.
- Latency with zero wait states: 3 cycles for ALU/branch/jump instructions, 4 for load/store. Each wait cycle on either port adds 1.
- Control inputs are sampled in EXEC, MEM and WB. The controller must hold them stable from EXEC through WB; they are combinational from Instr.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - With NREGS=16, indices ≥16 read 0 and writes to them are dropped.
  - Register reads are combinational.
  - There is no same-cycle read/write hazard, because WB and EXEC never coincide.
- Arithmetic:
  - Add/sub wrap modulo 2^XLEN.
  - slt is a signed compare.
  - Zero = (ALU result == 0).
  - B and J immediates have bit 0 = 0. U immediate is {IR[31:12],12'b0}, sign-extended.
- Reset, applied in any state including mid-MEM or mid-FETCH:
  - Next edge: state=FETCH, PC=RESET_PC, IR=0x00000013, ALUOut=0, Zero=0, all registers 0.
  - While rst_n=1: imem_req, dmem_req, dmem_we and instr_done are forced to 0.
  - A pending memory response arriving during reset is ignored.
- A ready asserted outside the matching state (imem_ready outside FETCH, dmem_ready outside MEM) is ignored.
- The PC does not change outside WB.

Test Plan:
- Reset release, RESET_PC=0x100, imem_ready tied 1 → imem_req=1 and PC=0x100 in the first cycle; instr_done first pulses 3 cycles later.
- addi x1,x0,5 then add x2,x1,x1 → x2=10; PC = 0x108 after the second WB; each instruction takes 3 cycles.
- sw x2,8(x0) with dmem_ready delayed 2 cycles → dmem_req held 3 cycles with addr=8, wdata=10, we=1; total instruction latency 6 cycles.
- beq x1,x1,-8 at PC=0x20 → PC=0x18 after WB. beq with x1≠x2 → PC=0x24.
- jal x1,+16 at PC=0x40 → x1=0x44, PC=0x50. lw into x0 → x0 stays 0.
- rst_n asserted during MEM with dmem_ready high in the same cycle → no register write, PC=RESET_PC, state FETCH next cycle.
